btb_ctrl: RTL and testbench

Controller that owns the 256-entry, 32-bit, 1W/1R BTB SRAM and presents fetch and branch-resolution interfaces. It packs and unpacks entries, and sweeps the array to invalid after reset or flush. It also forwards a same-cycle update to a colliding lookup, because the SRAM writes two clock edges after the request is presented. It sits between the fetch stage (lookup), the branch unit (update) and one btb_array instance.

---
 rtl/btb_pkg.sv | 30 +++
 rtl/btb_array.sv | 35 +++
 rtl/btb_ctrl.sv | 114 +++++++++++
 tb/tb_btb_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared BTB definitions: geometry, packed entry layout, controller state and PC field helpers.
package btb_pkg;

  localparam int IDX_W   = 8;
  localparam int TAG_W   = 7;
  localparam int TGT_W   = 24;
  localparam int ENTRIES = 1 << IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
  } btb_entry_t;

  localparam int ENTRY_W = $bits(btb_entry_t);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic logic [IDX_W-1:0] btb_idx(input logic [31:0] pc);
    return IDX_W'(pc >> 2);
  endfunction

  function automatic logic [TAG_W-1:0] btb_tag(input logic [31:0] pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

endpackage

// File: rtl/btb_array.sv
// 1W/1R BTB SRAM model: both ports register their request on the clock edge; writes land one edge later.
module btb_array
  import btb_pkg::*;
(
  input  logic               clk0,
  input  logic               csb0,
  input  logic [IDX_W-1:0]   addr0,
  input  logic [ENTRY_W-1:0] din0,
  input  logic               clk1,
  input  logic               csb1,
  input  logic [IDX_W-1:0]   addr1,
  output logic [ENTRY_W-1:0] dout1
);

  logic [ENTRY_W-1:0] mem [ENTRIES];
  logic               csb0_q;
  logic [IDX_W-1:0]   addr0_q;
  logic [ENTRY_W-1:0] din0_q;
  logic [IDX_W-1:0]   addr1_q;

  // NOTE: the array and its port registers have no reset, like the real macro; the controller's sweep defines contents.
  always_ff @(posedge clk0) begin
    csb0_q  <= csb0;
    addr0_q <= addr0;
    din0_q  <= din0;
    if (!csb0_q) mem[addr0_q] <= din0_q;
  end

  always_ff @(posedge clk1) begin
    if (!csb1) addr1_q <= addr1;
  end

  assign dout1 = mem[addr1_q];

endmodule

// File: rtl/btb_ctrl.sv
// BTB controller: fetch lookup, branch update, and invalidation sweep after reset/flush.
// Define BTB_CTRL_FWD_EN to forward a same-cycle accepted update into a colliding lookup.
module btb_ctrl
  import btb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [31:0] resp_target,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  output logic        busy
);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   sweep_cnt, sweep_cnt_nx;
  logic               upd_fire;
  btb_entry_t         upd_entry, rd_entry;
  logic               csb0, csb1;
  logic [IDX_W-1:0]   addr0, addr1;
  logic [ENTRY_W-1:0] din0, dout1;
  logic               lookup_valid_q, init_q;
  logic [31:0]        lookup_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nx;
      sweep_cnt <= sweep_cnt_nx;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nx     = state;
    sweep_cnt_nx = sweep_cnt;
    if (flush) begin
      state_nx     = INIT;
      sweep_cnt_nx = '0;
    end else if (state == INIT) begin
      sweep_cnt_nx = sweep_cnt + 1'b1;
      if (&sweep_cnt) state_nx = RUN;
    end
  end

  assign busy      = (state == INIT);
  assign upd_ready = (state == RUN) && !flush;
  assign upd_fire  = upd_valid && upd_ready;
  assign upd_entry = '{valid: 1'b1, tag: btb_tag(upd_pc), target: TGT_W'(upd_target >> 2)};

  // The sweep owns the write port while busy; updates are never accepted then.
  assign csb0  = !(busy || upd_fire);
  assign addr0 = busy ? sweep_cnt : btb_idx(upd_pc);
  assign din0  = busy ? '0 : upd_entry;
  assign csb1  = !lookup_valid;
  assign addr1 = btb_idx(lookup_pc);

  btb_array u_array (
    .clk0  (clk),
    .csb0  (csb0),
    .addr0 (addr0),
    .din0  (din0),
    .clk1  (clk),
    .csb1  (csb1),
    .addr1 (addr1),
    .dout1 (dout1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_valid_q <= 1'b0;
      lookup_pc_q    <= '0;
      init_q         <= 1'b1;
    end else begin
      lookup_valid_q <= lookup_valid;
      lookup_pc_q    <= lookup_pc;
      init_q         <= busy;
    end
  end

`ifdef BTB_CTRL_FWD_EN
  logic       fwd_q;
  btb_entry_t fwd_entry_q;

  // The array commits a write one edge after its request registers, so a same-cycle reader needs the bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q       <= 1'b0;
      fwd_entry_q <= '0;
    end else begin
      fwd_q       <= upd_fire && lookup_valid && (btb_idx(upd_pc) == btb_idx(lookup_pc));
      fwd_entry_q <= upd_entry;
    end
  end

  assign rd_entry = fwd_q ? fwd_entry_q : btb_entry_t'(dout1);
`else
  assign rd_entry = btb_entry_t'(dout1);
`endif

  assign resp_valid  = lookup_valid_q;
  assign resp_hit    = lookup_valid_q && !init_q && rd_entry.valid
                       && (rd_entry.tag == btb_tag(lookup_pc_q));
  assign resp_target = resp_hit ? {lookup_pc_q[31:TGT_W+2], rd_entry.target, 2'b00} : '0;

endmodule

// File: tb/tb_btb_ctrl.sv
// Scoreboard bench for btb_ctrl: directed scenarios plus random traffic against an index-keyed reference model.
`timescale 1ns/1ps
module tb_btb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_target;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        busy;

  btb_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_target  (resp_target),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        hit;
    logic [31:0] target;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  // Reference model: per-index contents plus cycles left in the invalidation sweep.
  bit          m_valid [256];
  logic [6:0]  m_tag   [256];
  logic [31:0] m_tgt   [256];
  int          m_sweep = 256;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hFF);
  endfunction

  function automatic logic [6:0] pc_tag(input logic [31:0] pc);
    return 7'((pc >> 10) & 32'h7F);
  endfunction

  task automatic check_ctrl();
    check("busy", busy, (m_sweep > 0));
    check("upd_ready", upd_ready, (m_sweep == 0) && !flush);
  endtask

  task automatic model_cycle();
    bit          acc;
    bit          hit;
    logic [31:0] tgt;
    int          li;
    exp_t        e;
    acc = upd_valid && (m_sweep == 0) && !flush;
    if (lookup_valid) begin
      li  = pc_idx(lookup_pc);
      hit = 1'b0;
      tgt = '0;
      if (m_sweep == 0) begin
`ifdef BTB_CTRL_FWD_EN
        if (acc && pc_idx(upd_pc) == li) begin
          hit = (pc_tag(upd_pc) == pc_tag(lookup_pc));
          tgt = upd_target;
        end else begin
          hit = m_valid[li] && (m_tag[li] == pc_tag(lookup_pc));
          tgt = m_tgt[li];
        end
`else
        hit = m_valid[li] && (m_tag[li] == pc_tag(lookup_pc));
        tgt = m_tgt[li];
`endif
      end
      e.hit    = hit;
      e.target = hit ? ((lookup_pc & 32'hFC00_0000) | (tgt & 32'h03FF_FFFC)) : 32'h0;
      e.pc     = lookup_pc;
      sb.push_back(e);
    end
    if (acc) begin
      m_valid[pc_idx(upd_pc)] = 1'b1;
      m_tag[pc_idx(upd_pc)]   = pc_tag(upd_pc);
      m_tgt[pc_idx(upd_pc)]   = upd_target;
    end
    if (flush) begin
      for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
      m_sweep = 256;
    end else if (m_sweep > 0) begin
      m_sweep--;
    end
  endtask

  task automatic cyc(input bit lv, input logic [31:0] lpc, input bit uv,
                     input logic [31:0] upc, input logic [31:0] utg, input bit fl);
    @(negedge clk);
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_target   = utg;
    flush        = fl;
    #1;
    check_ctrl();
    model_cycle();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1'b1, pc, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tg);
    cyc(1'b0, '0, 1'b1, pc, tg, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    flush        = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("rst_busy", busy, 1'b1);
    check("rst_upd_ready", upd_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_hit", resp_hit, 1'b0);
    check("rst_resp_target", resp_target, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_sweep = 256;
    #1;
    check_ctrl();
    model_cycle();
  endtask

  // Monitor: pops one expectation per presented response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: got resp_valid=1 with no lookup pending (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check($sformatf("resp_hit pc=%h", e.pc), resp_hit, e.hit);
          check($sformatf("resp_target pc=%h", e.pc), resp_target, e.target);
        end
      end
    end
  end

  initial begin
    logic [31:0] r, pc, tg;
    do_reset();

    // Sweep with an update held pending; one lookup mid-sweep must miss.
    for (int i = 0; i < 255; i++)
      cyc(i == 20, 32'h0000_1000, 1'b1, 32'h0000_0404, 32'h0000_9000, 1'b0);
    idle();
    idle();

    // Basic hit, then tag alias on the same index.
    upd(32'h0000_0404, 32'h0000_2000);
    idle();
    look(32'h0000_0404);
    look(32'h0000_0804);
    idle();

    // Same-cycle collision, then a lookup one cycle later.
    cyc(1'b1, 32'h0000_040C, 1'b1, 32'h0000_040C, 32'h0000_3000, 1'b0);
    look(32'h0000_040C);
    // Lookup then update of the same index next cycle: pre-update contents.
    look(32'h0000_0410);
    upd(32'h0000_0410, 32'h0000_5000);
    look(32'h0000_0410);
    idle();

    // Flush mid-run with a simultaneous update and a lookup.
    upd(32'h2000_0020, 32'h0000_1110);
    upd(32'h2000_0424, 32'h0123_4560);
    upd(32'h0000_1828, 32'hFFFF_FFFC);
    upd(32'h1234_5C2C, 32'h0000_0008);
    look(32'h1234_5C2C);
    cyc(1'b1, 32'h2000_0020, 1'b1, 32'h0000_0030, 32'h0000_7000, 1'b1);
    for (int i = 0; i < 256; i++) idle();
    look(32'h2000_0020);
    look(32'h2000_0424);
    look(32'h0000_1828);
    look(32'h1234_5C2C);
    look(32'h0000_0030);
    idle();

    // Random traffic over a small index/tag pool to force hits, aliases and collisions.
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom;
      pc = (r & ~32'h0001_FFFC) | (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
      r  = $urandom;
      tg = $urandom;
      if ($urandom_range(0, 1) == 1)
        r = (pc & 32'h0001_FFFC) | (r & ~32'h0001_FFFC);
      else
        r = (r & ~32'h0001_FFFC) | (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
      cyc($urandom_range(0, 9) < 7, pc, $urandom_range(0, 1) == 1, r, tg, $urandom_range(0, 399) == 0);
    end
    idle();
    idle();

    // Reset in the middle of a sweep.
    cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 100; i++) idle();
    check("sb_before_reset", sb.size(), 32'd0);
    do_reset();
    for (int i = 0; i < 255; i++)
      cyc($urandom_range(0, 1) == 1, $urandom, 1'b1, $urandom, $urandom, 1'b0);
    upd(32'h0000_0404, 32'h0000_2000);
    idle();
    look(32'h0000_0404);
    look(32'h0000_0408);
    idle();
    idle();

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
